iterative_muldiv_alu: RTL and testbench
=======================================

ITERATIVE_MULDIV_ALU -- requirements
Module: iterative_muldiv_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64, even).
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width, equal to clog2(WIDTH).
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  when high, freezes every register in the block.
REQ-006 SHALL have port A  input  WIDTH  operand A (rs).
REQ-007 SHALL have port B  input  WIDTH  operand B (rt).
REQ-008 SHALL have port operation  input  5  ALUOP code; encodings come from the shared constants.
REQ-009 SHALL have port shamt  input  SHAMT_W  shift amount.
REQ-010 SHALL have port start  input  1  launches MULT/MULTU/DIV/DIVU when sampled high in IDLE.
REQ-011 SHALL have port result  output  WIDTH  single-cycle result, combinational.
REQ-012 SHALL have port overflow  output  1  signed add/sub overflow, combinational.
REQ-013 SHALL have port busy  output  1  high while a multi-cycle operation is in flight.
REQ-014 SHALL have port done  output  1  one-cycle pulse when HI/LO are updated.
REQ-015 SHALL have port div_by_zero  output  1  sticky flag; set by DIV/DIVU with B==0, cleared by the next accepted start.
REQ-016 SHALL have port hazard  output  1  high when operation is MFHI/MFLO and busy is high.

Function
REQ-017 SHALL compute ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL and SRA combinationally at WIDTH bits, with SRA an arithmetic right shift of B.
REQ-018 SHALL assert overflow only for ADD when the operands' signs match and the result's sign differs from A, and only for SUB when the operands' signs differ and the result's sign differs from A; overflow SHALL be 0 for every other operation.
REQ-019 SHALL drive result to HI for MFHI and to LO for MFLO, and to all zeros for undefined codes (never X).
REQ-020 SHALL implement the FSM IDLE -> RUN -> FIX -> IDLE; start with a MULT/MULTU/DIV/DIVU code in IDLE at edge E0 SHALL latch A, B, the operation and the signedness, and enter RUN.
REQ-021 SHALL perform one iteration per unstalled cycle in RUN, WIDTH iterations in total: shift-add for multiply, restoring shift-subtract for divide.
REQ-022 SHALL apply the sign correction in FIX, write HI/LO at the FIX edge and pulse done in the following cycle; with no stall, HI/LO update at edge E(WIDTH+1).
REQ-023 SHALL hold busy high from after E0 until the FIX edge.
REQ-024 SHALL place the upper half of the 2*WIDTH product in HI and the lower half in LO; signed multiply SHALL use operand magnitudes and negate the product when the operand signs differ.
REQ-025 SHALL produce a quotient in LO truncated toward zero and a remainder in HI carrying the dividend's sign.
REQ-026 SHALL, for a divide with B==0, skip RUN, go straight to FIX, write LO=all ones and HI=A, and set div_by_zero.
REQ-027 SHALL ignore start when not in IDLE or when operation is not multi-cycle.
REQ-028 SHALL let stall freeze the FSM, counter, HI, LO and the done pulse; a done pulse coinciding with stall SHALL persist until the first unstalled cycle.
REQ-029 SHALL keep single-cycle operations fully usable while busy (except MFHI/MFLO, which raise hazard).

Reset
REQ-030 SHALL, on reset assertion, immediately force state=IDLE, counter=0, HI=0, LO=0, busy=0, done=0 and div_by_zero=0.
REQ-031 SHALL, on reset mid-operation, abandon the operation and leave HI/LO at zero.

Structure
REQ-032 SHALL take the ALUOP encodings (including new MULT, MULTU, DIV, DIVU, MFHI, MFLO and SRA) and the FSM state encoding from the shared constants file.
REQ-033 SHALL place the iterative datapath in one sub-module, muldiv_iterator (WIDTH-parametrised, with clock, reset, stall, load, step and mode inputs).

Verification
REQ-034 SHALL check that ADD with A=0x7FFFFFFF, B=1 gives result 0x80000000 and overflow=1, and that ADDU with the same operands gives overflow=0.
REQ-035 SHALL check that MULT with A=0xFFFFFFFE (-2), B=3 gives done at edge 33 with HI=0xFFFFFFFF and LO=0xFFFFFFFA, with busy high over edges 1..33.
REQ-036 SHALL check that DIV with A=-7, B=2 gives LO=0xFFFFFFFD and HI=0xFFFFFFFF, and that DIVU with A=7, B=2 gives LO=3 and HI=1.
REQ-037 SHALL check that DIVU with B=0, A=0x1234 gives div_by_zero=1, LO=0xFFFFFFFF and HI=0x1234 within 2 cycles.
REQ-038 SHALL check that holding stall for 5 cycles mid-RUN delays done by exactly 5 cycles, and that MFLO raised during busy gives hazard=1.
REQ-039 SHALL check that asserting reset at iteration 10 of MULTU gives busy=0, HI=LO=0 and no done pulse, and that a subsequent start proceeds normally.

Source files
------------

// File: rtl/iterative_muldiv_alu_pkg.sv
// Shared constants for the iterative multiply/divide ALU.
// Holds the ALUOP encodings, the sequencer state encoding and the
// datapath mode used by the iterator sub-module.
package iterative_muldiv_alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_ADDU  = 5'd1,
        ALU_SUB   = 5'd2,
        ALU_SUBU  = 5'd3,
        ALU_AND   = 5'd4,
        ALU_OR    = 5'd5,
        ALU_XOR   = 5'd6,
        ALU_NOR   = 5'd7,
        ALU_SLT   = 5'd8,
        ALU_SLTU  = 5'd9,
        ALU_SLL   = 5'd10,
        ALU_SRL   = 5'd11,
        ALU_SRA   = 5'd12,
        ALU_MULT  = 5'd13,
        ALU_MULTU = 5'd14,
        ALU_DIV   = 5'd15,
        ALU_DIVU  = 5'd16,
        ALU_MFHI  = 5'd17,
        ALU_MFLO  = 5'd18
    } aluop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_e;

endpackage

// File: rtl/muldiv_iterator.sv
// Iterative unsigned multiply/divide datapath.
// Ports:
//   clock, reset   - clock and asynchronous active-high reset
//   stall          - freezes all registers
//   load           - loads opA_i into LO, opB_i as multiplicand/divisor, clears HI
//   step           - performs one shift-add (MUL) or restoring shift-subtract (DIV) iteration
//   mode           - MODE_MUL or MODE_DIV
//   hi_o, lo_o     - raw unsigned upper/lower halves (product, or remainder/quotient)
module muldiv_iterator
    import iterative_muldiv_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             load,
    input  logic             step,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] opA_i,
    input  logic [WIDTH-1:0] opB_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH-1:0] divDiff;

    // One iteration per step. Multiply keeps {HI,LO} as a right-shifting
    // product register with the multiplier draining out of LO. Divide shifts
    // the dividend out of LO's top into HI and the quotient bits in at LO's bottom;
    // the low WIDTH bits of the difference suffice because a successful
    // subtraction always leaves a value below the divisor.
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        divShift = {hi_q, lo_q[WIDTH-1]};
        divDiff  = divShift[WIDTH-1:0] - opnd_q;
        if (load) begin
            hi_d   = '0;
            lo_d   = opA_i;
            opnd_d = opB_i;
        end else if (step) begin
            if (mode == MODE_MUL) begin
                hi_d = mulSum[WIDTH:1];
                lo_d = {mulSum[0], lo_q[WIDTH-1:1]};
            end else if (divShift >= {1'b0, opnd_q}) begin
                hi_d = divDiff;
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = divShift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Datapath registers, frozen by stall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else if (!stall) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/iterative_muldiv_alu.sv
// MIPS-style ALU with single-cycle operations and an iterative
// MULT/MULTU/DIV/DIVU unit writing the HI/LO pair.
// Ports:
//   clock, reset, stall - clock, async active-high reset, global freeze
//   A, B, operation     - operands and ALUOP code
//   shamt, start        - shift amount; launches multi-cycle ops from IDLE
//   result, overflow    - combinational single-cycle result and signed overflow
//   busy, done          - multi-cycle op in flight; one-cycle HI/LO-updated pulse
//   div_by_zero, hazard - sticky divide-by-zero flag; MFHI/MFLO read while busy
module iterative_muldiv_alu
    import iterative_muldiv_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [4:0]         operation,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               start,
    output logic [WIDTH-1:0]   result,
    output logic               overflow,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic               hazard
);

    localparam int CNT_W = $clog2(WIDTH);

    aluop_e           op;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] hi_q, lo_q, aHold_q, hiNext, loNext;
    logic             bNeg_q, isSigned_q, isDiv_q, done_q, divZero_q;
    logic             isMulti, opIsDiv, opSigned, accept, zeroDivisor;
    logic             load, step, writeHiLo, aNeg, negProd;
    logic [WIDTH-1:0] aMag, bMag, itHi, itLo, sumAdd, diffSub;
    logic [2*WIDTH-1:0] prodFix;

    assign op          = aluop_e'(operation);
    assign isMulti     = op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
    assign opIsDiv     = op inside {ALU_DIV, ALU_DIVU};
    assign opSigned    = op inside {ALU_MULT, ALU_DIV};
    assign accept      = (state_q == ST_IDLE) && start && isMulti;
    assign zeroDivisor = (B == '0);

    // Signed operations iterate on magnitudes; the most negative value maps
    // onto its own bit pattern, which is the correct unsigned magnitude.
    assign aMag = (opSigned && A[WIDTH-1]) ? ({WIDTH{1'b0}} - A) : A;
    assign bMag = (opSigned && B[WIDTH-1]) ? ({WIDTH{1'b0}} - B) : B;

    muldiv_iterator #(.WIDTH(WIDTH)) u_iterator (
        .clock (clock),
        .reset (reset),
        .stall (stall),
        .load  (load),
        .step  (step),
        .mode  (opIsDiv && (state_q == ST_IDLE) ? MODE_DIV :
                (state_q == ST_IDLE) ? MODE_MUL : mode_e'(isDiv_q)),
        .opA_i (aMag),
        .opB_i (bMag),
        .hi_o  (itHi),
        .lo_o  (itLo)
    );

    // Sequencer: a divide by zero skips RUN so its fixed answer lands one edge after start.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        load      = 1'b0;
        step      = 1'b0;
        writeHiLo = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = (opIsDiv && zeroDivisor) ? ST_FIX : ST_RUN;
                end
            end
            ST_RUN: begin
                step    = 1'b1;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                writeHiLo = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sign correction: negate product/quotient when operand signs differ;
    // the remainder follows the dividend's sign.
    always_comb begin
        aNeg    = isSigned_q && aHold_q[WIDTH-1];
        negProd = aNeg ^ bNeg_q;
        prodFix = negProd ? ({(2*WIDTH){1'b0}} - {itHi, itLo}) : {itHi, itLo};
        hiNext  = prodFix[2*WIDTH-1:WIDTH];
        loNext  = prodFix[WIDTH-1:0];
        if (isDiv_q) begin
            if (divZero_q) begin
                hiNext = aHold_q;
                loNext = '1;
            end else begin
                hiNext = aNeg ? ({WIDTH{1'b0}} - itHi) : itHi;
                loNext = negProd ? ({WIDTH{1'b0}} - itLo) : itLo;
            end
        end
    end

    // Control and HI/LO registers; stall holds everything including done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            aHold_q    <= '0;
            bNeg_q     <= 1'b0;
            isSigned_q <= 1'b0;
            isDiv_q    <= 1'b0;
            done_q     <= 1'b0;
            divZero_q  <= 1'b0;
        end else if (!stall) begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= writeHiLo;
            if (accept) begin
                aHold_q    <= A;
                bNeg_q     <= opSigned && B[WIDTH-1];
                isSigned_q <= opSigned;
                isDiv_q    <= opIsDiv;
                divZero_q  <= opIsDiv && zeroDivisor;
            end
            if (writeHiLo) begin
                hi_q <= hiNext;
                lo_q <= loNext;
            end
        end
    end

    assign sumAdd  = A + B;
    assign diffSub = A - B;

    // Single-cycle result path; undefined codes return zero.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                result   = sumAdd;
                overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sumAdd[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_ADDU: result = sumAdd;
            ALU_SUB: begin
                result   = diffSub;
                overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diffSub[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_SUBU: result = diffSub;
            ALU_AND:  result = A & B;
            ALU_OR:   result = A | B;
            ALU_XOR:  result = A ^ B;
            ALU_NOR:  result = ~(A | B);
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_SLL:  result = B << shamt;
            ALU_SRL:  result = B >> shamt;
            ALU_SRA:  result = $signed(B) >>> shamt;
            ALU_MFHI: result = hi_q;
            ALU_MFLO: result = lo_q;
            default:  result = '0;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign div_by_zero = divZero_q;
    assign hazard      = (op == ALU_MFHI || op == ALU_MFLO) && busy;

endmodule

// File: tb/tb_iterative_muldiv_alu.sv
// Directed self-checking bench for iterative_muldiv_alu (WIDTH=32).
module tb_iterative_muldiv_alu;
    import iterative_muldiv_alu_pkg::*;

    logic        clock = 1'b0;
    logic        reset, stall, start;
    logic [31:0] A, B, result;
    logic [4:0]  operation, shamt;
    logic        overflow, busy, done, div_by_zero, hazard;
    int          nCompared = 0;
    int          nMismatched = 0;
    int          edges;
    int          doneSeen;

    iterative_muldiv_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .A           (A),
        .B           (B),
        .operation   (operation),
        .shamt       (shamt),
        .start       (start),
        .result      (result),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hazard      (hazard)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input aluop_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        operation = op;
        A         = a;
        B         = b;
        shamt     = sh;
        #1;
    endtask

    task automatic runOp(input string tag, input aluop_e op, input logic [31:0] a, input logic [31:0] b, output int n);
        applyStimulus(op, a, b, 5'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checkOutput({tag, " done"}, {63'd0, done}, 64'd1);
    endtask

    task automatic checkHiLo(input string tag, input logic [31:0] expHi, input logic [31:0] expLo);
        applyStimulus(ALU_MFHI, 32'd0, 32'd0, 5'd0);
        checkOutput({tag, " HI"}, {32'd0, result}, {32'd0, expHi});
        applyStimulus(ALU_MFLO, 32'd0, 32'd0, 5'd0);
        checkOutput({tag, " LO"}, {32'd0, result}, {32'd0, expLo});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; start = 1'b0;
        A = '0; B = '0; operation = '0; shamt = '0;
        tick();
        tick();
        checkOutput("reset busy", {63'd0, busy}, 64'd0);
        checkOutput("reset done", {63'd0, done}, 64'd0);
        checkOutput("reset dbz", {63'd0, div_by_zero}, 64'd0);
        checkHiLo("reset", 32'h0, 32'h0);
        reset = 1'b0;
        tick();

        // Single-cycle operations
        applyStimulus(ALU_ADD, 32'h7FFFFFFF, 32'h1, 5'd0);
        checkOutput("add result", {32'd0, result}, 64'h80000000);
        checkOutput("add ovf", {63'd0, overflow}, 64'd1);
        applyStimulus(ALU_ADDU, 32'h7FFFFFFF, 32'h1, 5'd0);
        checkOutput("addu result", {32'd0, result}, 64'h80000000);
        checkOutput("addu ovf", {63'd0, overflow}, 64'd0);
        applyStimulus(ALU_SUB, 32'h80000000, 32'h1, 5'd0);
        checkOutput("sub result", {32'd0, result}, 64'h7FFFFFFF);
        checkOutput("sub ovf", {63'd0, overflow}, 64'd1);
        applyStimulus(ALU_SUBU, 32'h0, 32'h1, 5'd0);
        checkOutput("subu result", {32'd0, result}, 64'hFFFFFFFF);
        checkOutput("subu ovf", {63'd0, overflow}, 64'd0);
        applyStimulus(ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
        checkOutput("and", {32'd0, result}, 64'hF000F000);
        applyStimulus(ALU_OR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
        checkOutput("or", {32'd0, result}, 64'hFFF0FFF0);
        applyStimulus(ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
        checkOutput("xor", {32'd0, result}, 64'h0FF00FF0);
        applyStimulus(ALU_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
        checkOutput("nor", {32'd0, result}, 64'h000F000F);
        applyStimulus(ALU_SLT, 32'hFFFFFFFF, 32'h1, 5'd0);
        checkOutput("slt", {32'd0, result}, 64'd1);
        applyStimulus(ALU_SLTU, 32'hFFFFFFFF, 32'h1, 5'd0);
        checkOutput("sltu", {32'd0, result}, 64'd0);
        applyStimulus(ALU_SLL, 32'h0, 32'h1, 5'd31);
        checkOutput("sll", {32'd0, result}, 64'h80000000);
        applyStimulus(ALU_SRL, 32'h0, 32'h80000000, 5'd4);
        checkOutput("srl", {32'd0, result}, 64'h08000000);
        applyStimulus(ALU_SRA, 32'h0, 32'h80000000, 5'd4);
        checkOutput("sra", {32'd0, result}, 64'hF8000000);
        operation = 5'd31; #1;
        checkOutput("undefined op", {32'd0, result}, 64'd0);

        // start with a single-cycle code is ignored
        applyStimulus(ALU_ADD, 32'h5, 32'h6, 5'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start ignored busy", {63'd0, busy}, 64'd0);

        // MULT -2 * 3 with an edge-by-edge busy/done trace
        applyStimulus(ALU_MULT, 32'hFFFFFFFE, 32'd3, 5'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("mult busy E0", {63'd0, busy}, 64'd1);
        for (int e = 1; e <= 33; e++) begin
            tick();
            checkOutput($sformatf("mult busy E%0d", e), {63'd0, busy}, {63'd0, (e <= 32)});
            checkOutput($sformatf("mult done E%0d", e), {63'd0, done}, {63'd0, (e == 33)});
        end
        tick();
        checkOutput("mult done E34", {63'd0, done}, 64'd0);
        checkHiLo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

        runOp("multu", ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, edges);
        checkOutput("multu edges", edges, 64'd33);
        checkHiLo("multu", 32'hFFFFFFFE, 32'h00000001);
        runOp("mult minneg", ALU_MULT, 32'h80000000, 32'h80000000, edges);
        checkHiLo("mult minneg", 32'h40000000, 32'h00000000);

        runOp("div", ALU_DIV, 32'hFFFFFFF9, 32'd2, edges);
        checkOutput("div edges", edges, 64'd33);
        checkHiLo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("div minneg", ALU_DIV, 32'h80000000, 32'd1, edges);
        checkHiLo("div minneg", 32'h0, 32'h80000000);

        // Divide by zero then a normal DIVU that clears the flag
        runOp("divu0", ALU_DIVU, 32'h1234, 32'd0, edges);
        checkOutput("divu0 edges", edges, 64'd1);
        checkOutput("divu0 dbz", {63'd0, div_by_zero}, 64'd1);
        checkHiLo("divu0", 32'h1234, 32'hFFFFFFFF);
        runOp("divu", ALU_DIVU, 32'd7, 32'd2, edges);
        checkOutput("divu dbz cleared", {63'd0, div_by_zero}, 64'd0);
        checkHiLo("divu", 32'd1, 32'd3);

        // Stall 5 cycles mid-RUN
        applyStimulus(ALU_MULTU, 32'd5, 32'd7, 5'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        repeat (10) begin tick(); edges++; end
        stall = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tick();
            edges++;
            if (s == 0) begin
                applyStimulus(ALU_ADD, 32'd1, 32'd2, 5'd0);
                checkOutput("add while busy", {32'd0, result}, 64'd3);
                applyStimulus(ALU_MFLO, 32'd0, 32'd0, 5'd0);
                checkOutput("mflo hazard", {63'd0, hazard}, 64'd1);
            end
        end
        checkOutput("stall busy", {63'd0, busy}, 64'd1);
        stall = 1'b0;
        while (done !== 1'b1 && edges < 100) begin tick(); edges++; end
        checkOutput("stall done", {63'd0, done}, 64'd1);
        checkOutput("stall edges", edges, 64'd38);
        stall = 1'b1;
        tick();
        checkOutput("done held by stall", {63'd0, done}, 64'd1);
        stall = 1'b0;
        tick();
        checkOutput("done released", {63'd0, done}, 64'd0);
        checkOutput("hazard idle", {63'd0, hazard}, 64'd0);
        checkHiLo("stall multu", 32'd0, 32'd35);

        // Reset at iteration 10 of MULTU
        applyStimulus(ALU_MULTU, 32'd3, 32'd4, 5'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        #1;
        checkOutput("midreset busy", {63'd0, busy}, 64'd0);
        checkOutput("midreset done", {63'd0, done}, 64'd0);
        checkHiLo("midreset", 32'd0, 32'd0);
        reset = 1'b0;
        doneSeen = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) doneSeen++;
        end
        checkOutput("midreset no done", doneSeen, 64'd0);
        checkHiLo("midreset later", 32'd0, 32'd0);
        runOp("after reset", ALU_MULTU, 32'd3, 32'd4, edges);
        checkOutput("after reset edges", edges, 64'd33);
        checkHiLo("after reset", 32'd0, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
